// File: rtl/pong_pkg.sv
// Shared definitions for the pong scoreboard: round state encoding, seven-segment
// glyphs and a constant-time BCD conversion helper.
package pong_pkg;

  typedef enum logic [1:0] {
    StIdle     = 2'd0,
    StPlaying  = 2'd1,
    StGameOver = 2'd2
  } state_e;

  // Active-high {g,f,e,d,c,b,a} patterns, hex digits 0..F; entry 0 is the rightmost.
  localparam logic [15:0][6:0] SegPatterns = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

  // Binary to packed BCD, least significant digit in the low nibble.
  function automatic logic [63:0] to_bcd(input int unsigned value);
    logic [63:0] result;
    int unsigned rest;
    result = '0;
    rest   = value;
    for (int i = 0; i < 16; i++) begin
      result[i*4 +: 4] = 4'(rest % 10);
      rest = rest / 10;
    end
    return result;
  endfunction

endpackage

// File: rtl/pong_bcd_counter.sv
// Multi-digit BCD up-counter with synchronous clear; one instance per player.
module pong_bcd_counter #(
  parameter int unsigned DIGITS = 2
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                inc,
  input  logic                clr,
  output logic [DIGITS*4-1:0] value
);

  logic [DIGITS*4-1:0] value_d, value_q;
  logic                carry;

  always_comb begin
    value_d = value_q;
    carry   = inc;
    // Ripple the decimal carry: a 9 rolls to 0 and passes the increment upward.
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (carry) begin
        if (value_q[i*4 +: 4] == 4'd9) begin
          value_d[i*4 +: 4] = 4'd0;
        end else begin
          value_d[i*4 +: 4] = value_q[i*4 +: 4] + 4'd1;
          carry = 1'b0;
        end
      end
    end
    if (clr) begin
      value_d = '0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      value_q <= '0;
    end else begin
      value_q <= value_d;
    end
  end

  assign value = value_q;

endmodule

// File: rtl/pong_scoreboard.sv
// Pong score keeper: per-player BCD scores, round FSM with winner detection and a
// time-multiplexed seven-segment display scan.
module pong_scoreboard
  import pong_pkg::*;
#(
  parameter int unsigned N_PLAYERS      = 2,
  parameter int unsigned DIGITS         = 2,
  parameter int unsigned WIN_SCORE      = 11,
  parameter int unsigned REFRESH_DIV    = 50000,
  parameter bit          SEG_ACTIVE_LOW = 1'b1
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          start,
  input  logic                          clear,
  input  logic [N_PLAYERS-1:0]          point,
  output logic [N_PLAYERS*DIGITS*4-1:0] scores,
  output logic [1:0]                    state,
  output logic                          game_over,
  output logic [2:0]                    winner,
  output logic [6:0]                    seg,
  output logic [N_PLAYERS*DIGITS-1:0]   digit_sel
);

  localparam int unsigned ScoreW    = DIGITS * 4;
  localparam int unsigned NumDigits = N_PLAYERS * DIGITS;
  localparam int unsigned IdxW      = $clog2(NumDigits);
  localparam int unsigned CntW      = $clog2(REFRESH_DIV + 1);

  if (N_PLAYERS < 2 || N_PLAYERS > 8) begin : g_bad_players
    $error("pong_scoreboard: N_PLAYERS must be in 2..8");
  end
  if (WIN_SCORE < 1 || WIN_SCORE > 10**DIGITS - 1) begin : g_bad_win
    $error("pong_scoreboard: WIN_SCORE must be in 1..10**DIGITS-1");
  end
  if (REFRESH_DIV < 1) begin : g_bad_div
    $error("pong_scoreboard: REFRESH_DIV must be at least 1");
  end

  // A score reaches WIN_SCORE exactly when it is incremented from WIN_SCORE-1.
  localparam logic [ScoreW-1:0] WinPrevBcd = ScoreW'(to_bcd(WIN_SCORE - 1));

  state_e                state_q;
  logic                  game_over_q;
  logic [2:0]            winner_q;
  logic [N_PLAYERS-1:0]  inc;
  logic [N_PLAYERS-1:0]  win_hit;
  logic                  score_clr;
  logic [2:0]            win_idx;

  assign inc       = (state_q == StPlaying && !clear) ? point : '0;
  assign score_clr = clear || (state_q == StGameOver && start);

  for (genvar p = 0; p < N_PLAYERS; p++) begin : g_player
    pong_bcd_counter #(
      .DIGITS (DIGITS)
    ) u_counter (
      .clock (clock),
      .reset (reset),
      .inc   (inc[p]),
      .clr   (score_clr),
      .value (scores[p*ScoreW +: ScoreW])
    );
    assign win_hit[p] = inc[p] && (scores[p*ScoreW +: ScoreW] == WinPrevBcd);
  end

  // Lowest-index player wins a tie.
  always_comb begin
    win_idx = '0;
    for (int i = int'(N_PLAYERS) - 1; i >= 0; i--) begin
      if (win_hit[i]) begin
        win_idx = 3'(i);
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      game_over_q <= 1'b0;
      winner_q    <= '0;
    end else if (clear) begin
      state_q     <= StIdle;
      game_over_q <= 1'b0;
      winner_q    <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            state_q <= StPlaying;
          end
        end
        StPlaying: begin
          if (|win_hit) begin
            state_q     <= StGameOver;
            game_over_q <= 1'b1;
            winner_q    <= win_idx;
          end
        end
        StGameOver: begin
          if (start) begin
            state_q     <= StPlaying;
            game_over_q <= 1'b0;
            winner_q    <= '0;
          end
        end
        default: begin
          state_q     <= StIdle;
          game_over_q <= 1'b0;
          winner_q    <= '0;
        end
      endcase
    end
  end

  assign state     = state_q;
  assign game_over = game_over_q;
  assign winner    = winner_q;

  logic [CntW-1:0] cnt_q;
  logic [IdxW-1:0] idx_q;
  logic [3:0]      nibble;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
      idx_q <= '0;
    end else if (cnt_q == CntW'(REFRESH_DIV - 1)) begin
      cnt_q <= '0;
      idx_q <= (idx_q == IdxW'(NumDigits - 1)) ? '0 : idx_q + IdxW'(1);
    end else begin
      cnt_q <= cnt_q + CntW'(1);
    end
  end

  // Display index k maps directly to nibble k of the packed score bus.
  assign nibble    = scores[{idx_q, 2'b00} +: 4];
  assign digit_sel = NumDigits'(1) << idx_q;
  assign seg       = SEG_ACTIVE_LOW ? ~SegPatterns[nibble] : SegPatterns[nibble];

endmodule

// File: doc/pong_scoreboard.md
# pong_scoreboard

Parametrised score keeper and display driver for the pong game family. Counts per-player points in BCD, runs the round state machine (idle, playing, game over), detects the winner at a configurable target score and drives a time-multiplexed seven-segment display. Sits between the game FSM, which supplies point pulses, and the board's seven-segment digits. It generalises the fixed two-player, single-digit score path to N players and multi-digit scores.

## Interface
- `N_PLAYERS`, 2: number of players; legal range 2–8.
- `DIGITS`, 2: BCD digits per score.
- `WIN_SCORE`, 11: score that ends the game.
  - Must satisfy 1 ≤ `WIN_SCORE` ≤ 10^`DIGITS`−1.
  - Elaboration fails otherwise.
- `REFRESH_DIV`, 50000: clock cycles each display digit stays selected; ≥ 1.
- `SEG_ACTIVE_LOW`, 1: 1 means a lit segment is driven 0.

Ports:
- `clock`, in, 1: single system clock.
- `reset`, in, 1: asynchronous, active-high reset.
- `start`, in, 1: one-cycle pulse that starts a new game.
- `clear`, in, 1: one-cycle pulse that aborts the game and returns to idle.
- `point`, in, `N_PLAYERS`: one-cycle pulses; bit i scores a point for player i.
- `scores`, out, `N_PLAYERS*DIGITS*4`: packed BCD scores, player 0 in the LSBs.
- `state`, out, 2: 0 = IDLE, 1 = PLAYING, 2 = GAME_OVER.
- `game_over`, out, 1: high while in GAME_OVER.
- `winner`, out, 3: index of the winning player; valid while `game_over` is high.
- `seg`, out, 7: segment bits `{g,f,e,d,c,b,a}`; polarity set by `SEG_ACTIVE_LOW`.
- `digit_sel`, out, `N_PLAYERS*DIGITS`: one-hot, active-high digit enable.

## Operation
- **Reset values:** all scores 0, `state`=IDLE, `game_over`=0, `winner`=0, refresh counter 0, display index 0, `digit_sel`=…0001, `seg` shows "0".
- **IDLE:**
  - `point` is ignored and scores stay 0.
  - `start` → PLAYING.
- **PLAYING:**
  - Each asserted `point[i]` increments player i's BCD score by 1, with decimal carry (…9 → …10, never 0xA).
  - All asserted bits are applied in the same cycle.
- **Win detection:**
  - Uses the post-increment value.
  - If any score equals `WIN_SCORE`, go to GAME_OVER and latch `winner`.
  - If several players reach `WIN_SCORE` in the same cycle, the lowest index wins.
- **GAME_OVER:**
  - `point` is ignored; scores and `winner` hold.
  - `start` → zero all scores, clear `winner`, go to PLAYING.
- **`start` while PLAYING:** ignored.
- **`clear` in any state:** zero scores, `winner`=0, go to IDLE.
  - `clear` has priority over `start` and `point` in the same cycle.
- **Saturation:** scores never exceed `WIN_SCORE`, since the game ends on reaching it. No wrap-around is possible.
- **Display scan:**
  - Display index k selects digit k%`DIGITS` of player k/`DIGITS`; digit 0 is the least significant.
  - `digit_sel` bit k = 1.
  - `seg` = decode of the selected BCD nibble, inverted when `SEG_ACTIVE_LOW`=1.
- **Display refresh:** after `REFRESH_DIV` cycles, k advances by one and wraps from `N_PLAYERS*DIGITS`−1 to 0. The scan runs in every state.

## Timing
- `point` or `start` sampled at edge t → `scores`, `state`, `game_over` and `winner` are updated at edge t+1. Latency is 1 cycle.
- `game_over` rises in the same cycle as the winning score appears on `scores`.
- `seg` is a combinational decode of registered index and scores. A score change is visible on `seg` in the same cycle it appears on `scores`, if that digit is selected.
- `digit_sel` and `seg` always change together, on the same edge.
- Asynchronous `reset` mid-game:
  - All outputs take their reset values immediately.
  - The first `start` is accepted at the first rising edge after `reset` deasserts.
- Multi-cycle pulses on `point` are counted once per cycle. Edge detection belongs upstream.

## Structure
- Shared package `pong_pkg` holds:
  - the state encoding constants (IDLE, PLAYING, GAME_OVER);
  - the 16-entry BCD-to-seven-segment active-high pattern constant.
- Sub-module `pong_bcd_counter`:
  - parameter `DIGITS`;
  - inputs `inc`, `clr`; output packed BCD value;
  - instantiated once per player.
- Top level holds the FSM, win comparison with priority encoder, refresh counter, display index and mux/decode.

## Test plan
1. **Reset mid-game:** after 5 points to player 0 in PLAYING, assert `reset` → `scores`=0, `state`=0, `game_over`=0, `digit_sel`=01 immediately.
2. **BCD carry:** defaults; `start`, then 10 `point`=2'b01 pulses → `scores[7:0]`=0x10 (not 0x0A); one more → 0x11, `game_over`=1, `winner`=0 at the next edge.
3. **Ignored points:** in IDLE and in GAME_OVER, `point`=2'b11 → `scores` unchanged. `start` from GAME_OVER → scores 0, `state`=1.
4. **Simultaneous win:** both players at 10, `point`=2'b11 → both scores 0x11, `winner`=0, `game_over`=1 one cycle later.
5. **Priority:** `clear` and `start` in the same cycle during PLAYING → `state`=IDLE, scores 0.
6. **Display scan:** `REFRESH_DIV`=4, scores 0x12 / 0x07 → `digit_sel` steps 0001 → 0010 → 0100 → 1000 → 0001, every 4 cycles. `seg` (active-low) shows 2, 1, 7, 0 in that order.
